// File: rtl/main_mem_pipe_if.sv
// Request/response bundle between the cache fill FSM and main_mem_pipe.
// Optional addr_err wire present when MAIN_MEM_ALIGN_CHECK_EN is defined.
interface main_mem_pipe_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // Handshake: no ready in either direction. A request is taken on every
   // rising edge with enable=1, and the requester must sink every cycle
   // in which data_valid=1.
   logic              enable;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
`ifdef MAIN_MEM_ALIGN_CHECK_EN
   logic              addr_err;

   modport master (output enable, wr, addr, data_in,
                   input  data_out, data_valid, addr_err);
   modport slave  (input  enable, wr, addr, data_in,
                   output data_out, data_valid, addr_err);
`else
   modport master (output enable, wr, addr, data_in,
                   input  data_out, data_valid);
   modport slave  (input  enable, wr, addr, data_in,
                   output data_out, data_valid);
`endif
endinterface

// File: rtl/main_mem_pipe.sv
// Fixed-latency pipelined single-port word memory with a byte-address port.
// Define MAIN_MEM_ALIGN_CHECK_EN to add the registered addr_err strobe.
module main_mem_pipe #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   main_mem_pipe_if.slave bus
);

   generate
      if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
         $error("main_mem_pipe: LATENCY must be within 1..8");
      end
      if (ADDR_W > DEPTH_LOG2 + 1) begin : g_hi_bits
         logic unused_hi;
         assign unused_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2+1];
      end
   endgenerate

   logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] idx;
   logic                  rd_fire;
   logic                  wr_fire;

   logic [LATENCY-1:0]    vld_q, vld_d;
   logic [DATA_W-1:0]     dat_q [LATENCY];
   logic [DATA_W-1:0]     dat_d [LATENCY];

   assign idx     = bus.addr[DEPTH_LOG2:1];
   assign rd_fire = bus.enable & ~bus.wr;
   assign wr_fire = bus.enable &  bus.wr;

   // Read data is captured at issue, so a later write never disturbs a read
   // already travelling down the pipe.
   always_comb begin
      vld_d    = '0;
      dat_d[0] = '0;
      vld_d[0] = rd_fire;
      if (rd_fire) begin
         dat_d[0] = mem_q[idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   // Array has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[idx] <= bus.data_in;
      end
   end

   assign bus.data_valid = vld_q[LATENCY-1];
   assign bus.data_out   = dat_q[LATENCY-1];

`ifdef MAIN_MEM_ALIGN_CHECK_EN
   logic addr_err_q, addr_err_d;

   always_comb begin
      addr_err_d = bus.enable & bus.addr[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign bus.addr_err = addr_err_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && bus.enable && bus.addr[0]) begin
         $display("main_mem_pipe: misaligned address 0x%h", bus.addr);
      end
   end
`endif
`else
   logic unused_lo;
   assign unused_lo = bus.addr[0];
`endif

endmodule

// File: tb/tb_main_mem_pipe.sv
// Directed bench for main_mem_pipe: a reference array predicts read data and
// a scoreboard of (data, arrival cycle) checks data_valid on every cycle.
module tb_main_mem_pipe;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int LAT    = 4;
   localparam int DLOG2  = 15;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;

   logic [DATA_W-1:0] exp_q[$];
   int                exp_cyc_q[$];
   logic [DATA_W-1:0] ref_mem [int];

   main_mem_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   main_mem_pipe #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .DEPTH_LOG2(DLOG2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // driver tasks: called just after a rising edge, request taken at the next one
   task automatic req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int k;
      k = int'(a[DLOG2:1]);
      bus.enable  = 1'b1;
      bus.wr      = w;
      bus.addr    = a;
      bus.data_in = d;
      if (w) begin
         ref_mem[k] = d;
      end else begin
         exp_q.push_back(ref_mem.exists(k) ? ref_mem[k] : 16'hxxxx);
         exp_cyc_q.push_back(cyc + LAT);
      end
      @(posedge clk); #1;
      bus.enable = 1'b0;
      bus.wr     = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.enable = 1'b0;
      bus.wr     = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // scoreboard monitor: every cycle either a predicted word arrives or nothing does
   always @(negedge clk) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
         chk("rd_valid", 32'(bus.data_valid), 32'd1);
         chk("rd_data", 32'(bus.data_out), 32'(exp_q[0]));
         void'(exp_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end else begin
         chk("idle_valid", 32'(bus.data_valid), 32'd0);
      end
      if (!rst_n) begin
         chk("rst_dout", 32'(bus.data_out), 32'd0);
      end
   end

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      bus.enable  = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = '0;
      bus.data_in = '0;
      #1;
      chk("reset_valid", 32'(bus.data_valid), 32'd0);
      chk("reset_dout", 32'(bus.data_out), 32'd0);
`ifdef MAIN_MEM_ALIGN_CHECK_EN
      chk("reset_addr_err", 32'(bus.addr_err), 32'd0);
`endif
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // write then read on the very next cycle
      req(1'b1, 16'h0010, 16'hBEEF);
      req(1'b0, 16'h0010, 16'h0000);
      idle(LAT + 1);

      // preload a line, then burst-read it back to back
      for (int i = 0; i < 8; i++) req(1'b1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
      for (int i = 0; i < 8; i++) req(1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
      idle(LAT + 1);

      // gapped reads: gap of one must reappear at the output
      req(1'b0, 16'h0100, 16'h0000);
      idle(1);
      req(1'b0, 16'h0102, 16'h0000);
      req(1'b0, 16'h0104, 16'h0000);
      idle(LAT + 1);

      // in-flight write hazard
      req(1'b1, 16'h0020, 16'h1111);
      idle(1);
      req(1'b0, 16'h0020, 16'h0000);
      req(1'b1, 16'h0020, 16'h2222);
      req(1'b0, 16'h0020, 16'h0000);
      idle(LAT + 2);

      // reset mid-operation: in-flight reads are dropped
      req(1'b0, 16'h0106, 16'h0000);
      req(1'b0, 16'h0108, 16'h0000);
      req(1'b0, 16'h010A, 16'h0000);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      #1;
      chk("async_rst_valid", 32'(bus.data_valid), 32'd0);
      chk("async_rst_dout", 32'(bus.data_out), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(LAT + 2);
      req(1'b0, 16'h0106, 16'h0000);
      req(1'b0, 16'h0108, 16'h0000);
      req(1'b0, 16'h010A, 16'h0000);
      idle(LAT + 1);

      // odd address aliases onto the even word
      req(1'b1, 16'h0031, 16'h5A5A);
`ifdef MAIN_MEM_ALIGN_CHECK_EN
      chk("addr_err_write", 32'(bus.addr_err), 32'd1);
`endif
      req(1'b0, 16'h0030, 16'h0000);
`ifdef MAIN_MEM_ALIGN_CHECK_EN
      chk("addr_err_read", 32'(bus.addr_err), 32'd0);
`endif
      idle(LAT + 2);

      // a few random reads over the words written so far
      for (int i = 0; i < 6; i++) begin
         req(1'b0, 16'(16'h0100 + 2 * $urandom_range(0, 7)), 16'h0000);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(LAT + 2);

      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
